sonic_vc_rx_pkt_fifo: RTL and testbench
=======================================

# sonic_vc_rx_pkt_fifo

Store-and-forward packet FIFO for the SoNIC virtual-channel receive path. It accepts Avalon-ST beats from the RX timing adapter, which presents them with ready latency 0. It holds each packet until its EOP beat has been written, then releases it downstream with ready latency 0. Packets that overflow or are malformed are dropped whole and never appear on the output.

## Interface
Parameters:
- DATA_W, 128, beat width in bits.
- EMPTY_W, 2, empty-symbol field width.
- DEPTH, 512, storage depth in beats; must be a power of 2.
- ADDR_W, $clog2(DEPTH), derived; not to be overridden.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- in_ready  out  1  low during reset, high in every cycle after; the block drops rather than backpressures.
- in_valid  in  1  input beat valid.
- in_data  in  DATA_W  input payload.
- in_startofpacket  in  1  SOP.
- in_endofpacket  in  1  EOP.
- in_empty  in  EMPTY_W  empty symbols; meaningful on EOP only.
- out_ready  in  1  downstream ready, latency 0.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output payload.
- out_startofpacket  out  1  SOP.
- out_endofpacket  out  1  EOP.
- out_empty  out  EMPTY_W  empty symbols.
- pkt_count  out  ADDR_W+1  committed packets whose EOP has not yet left the output.
- drop_count  out  32  dropped packets; saturates at 0xFFFFFFFF.

## Operation
Storage and pointers:
- Each RAM entry holds {data, sop, eop, empty}, 132 bits at default parameters.
- Three pointers, each ADDR_W+1 bits: wr_ptr (tentative), wr_commit, rd_ptr.
- Full: wr_ptr − rd_ptr == DEPTH.
- Data available to the read side: rd_ptr != wr_commit.
- A beat is accepted when in_valid && in_ready.

Input FSM states: IDLE, PKT, DROP.
- IDLE, SOP beat, not full: write the beat, wr_ptr++.
  - If EOP is also set: commit, stay in IDLE.
  - Otherwise: go to PKT.
- IDLE, SOP beat, full: drop_count++, go to DROP (stay in IDLE if EOP is set).
- IDLE, non-SOP beat (orphan): discard, no count.
- PKT, normal beat, not full: write it; if EOP, commit and go to IDLE.
- PKT, beat arrives while full: wr_ptr ← wr_commit, drop_count++, go to DROP (go to IDLE if the beat has EOP).
- PKT, SOP beat (missing EOP): wr_ptr ← wr_commit, drop_count++, then handle the beat exactly as an IDLE SOP in the same cycle.
- DROP, non-SOP beat: discard; EOP returns to IDLE.
- DROP, SOP beat: handle as an IDLE SOP.

Commit rules:
- Commit sets wr_commit ← wr_ptr + 1, i.e. the address after the EOP beat.
- Commit increments pkt_count.
- Any packet longer than DEPTH beats is always dropped.

Read side:
- RAM has 1-cycle registered read latency.
- A prefetch stage of 2 output registers sustains one beat per cycle while out_ready=1.
- Output holds all out_* stable while out_valid && !out_ready.

pkt_count:
- Increments on commit.
- Decrements on out_valid && out_ready && out_endofpacket.
- Both in the same cycle: unchanged.

## Timing
Reset values:
- Pointers 0; FSM in IDLE.
- pkt_count 0, drop_count 0.
- out_valid 0, out_data 0, out_startofpacket 0, out_endofpacket 0, out_empty 0.
- in_ready 0.

Latency:
- With the output side empty, out_valid for the SOP beat rises 2 cycles after the cycle in which the EOP beat is accepted.
- Beats of a packet never appear on the output before that packet's EOP has been accepted.

Throughput:
- 1 beat/cycle in, and 1 beat/cycle out.
- Back-to-back committed packets stream out with no idle cycle.

Simultaneous events:
- Read and write in the same cycle are legal.
- Full is evaluated with the rd_ptr value before that cycle's read, which is conservative.

Reset mid-operation:
- Synchronous reset discards every stored and partial packet.
- Outputs return to their reset values on the next edge.

## Structure
- Package sonic_vc_pkg holds:
  - DATA_W and EMPTY_W defaults.
  - The input FSM enum {IDLE, PKT, DROP}.
  - The storage-entry struct {data, sop, eop, empty}.
- Sub-module sonic_vc_sdp_ram: simple dual-port RAM, parameterized width and depth, 1-cycle registered read.
- Pointer/FSM logic and the prefetch output stage live in the top module.

## Test plan
All scenarios use DEPTH=16.
- Single 1-beat packet (SOP+EOP, empty=2, data=0xA5…), out_ready=1:
  - out_valid rises exactly 2 cycles after acceptance with identical fields.
  - pkt_count goes 0→1→0.
- Three 4-beat packets back to back, out_ready=1:
  - 12 output beats on 12 consecutive cycles, in order.
  - drop_count=0.
- out_ready=0 while a 20-beat packet follows a committed 4-beat packet:
  - The 20-beat packet is dropped and drop_count=1.
  - When out_ready rises, only the 4 committed beats emerge.
- SOP beat, 2 beats, then a new SOP without EOP, then a 3-beat packet ending in EOP:
  - drop_count=1.
  - Only the 3-beat packet is output.
- Orphan non-SOP beats while IDLE:
  - Nothing output, drop_count stays 0.
- Reset asserted in the middle of a packet with 2 committed packets stored:
  - After reset, out_valid=0, pkt_count=0, drop_count=0.
  - A subsequent 2-beat packet passes through correctly.

Source files
------------

// File: rtl/sonic_vc_pkg.sv
// Shared types and defaults for the SoNIC virtual-channel receive packet FIFO.
// The entry struct uses the default widths; the FIFO rebuilds the same layout for its own parameters.
package sonic_vc_pkg;

    localparam int SONIC_VC_DATA_W  = 128;
    localparam int SONIC_VC_EMPTY_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [SONIC_VC_DATA_W-1:0]  data;
        logic                        sop;
        logic                        eop;
        logic [SONIC_VC_EMPTY_W-1:0] empty;
    } sonic_vc_entry_t;

    function automatic int entry_width(input int data_w, input int empty_w);
        return data_w + 2 + empty_w;
    endfunction

endpackage

// File: rtl/sonic_vc_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a single registered read stage.
// No reset on the array or the read register so it maps onto block RAM.
module sonic_vc_sdp_ram #(
    parameter int WIDTH  = 132,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sonic_vc_rx_pkt_fifo.sv
// Store-and-forward packet FIFO: packets become visible to the read side only once their EOP
// is written; overflowing or truncated packets are rolled back and counted as drops.
module sonic_vc_rx_pkt_fifo
    import sonic_vc_pkg::*;
#(
    parameter int DATA_W  = SONIC_VC_DATA_W,
    parameter int EMPTY_W = SONIC_VC_EMPTY_W,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               in_ready,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    output logic [ADDR_W:0]    pkt_count,
    output logic [31:0]        drop_count
);

    localparam int PTR_W   = ADDR_W + 1;
    localparam int ENTRY_W = entry_width(DATA_W, EMPTY_W);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } entry_t;

    // ---------------- write side ----------------
    rx_state_e        state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] wr_commit_reg, wr_commit_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] base_ptr;
    logic             in_ready_reg;
    logic             accept;
    logic             ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    entry_t           wr_entry;
    logic [1:0]       drop_inc;
    logic             commit_evt;

    assign in_ready = in_ready_reg;
    assign accept   = in_valid && in_ready_reg;

    always_comb begin
        wr_entry.data  = in_data;
        wr_entry.sop   = in_startofpacket;
        wr_entry.eop   = in_endofpacket;
        wr_entry.empty = in_empty;
    end

    // A SOP inside PKT first rolls back the truncated packet, then is treated like a fresh SOP,
    // so a single beat can account for two drops (truncation plus no room for the new packet).
    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        wr_commit_next = wr_commit_reg;
        ram_we         = 1'b0;
        ram_waddr      = wr_ptr_reg[ADDR_W-1:0];
        drop_inc       = 2'd0;
        commit_evt     = 1'b0;
        base_ptr       = wr_ptr_reg;
        if (accept) begin
            if (in_startofpacket) begin
                if (state_reg == PKT) begin
                    base_ptr = wr_commit_reg;
                    drop_inc = 2'd1;
                end
                if ((base_ptr - rd_ptr_reg) == DEPTH_P) begin
                    drop_inc    = drop_inc + 2'd1;
                    wr_ptr_next = base_ptr;
                    state_next  = in_endofpacket ? IDLE : DROP;
                end else begin
                    ram_we      = 1'b1;
                    ram_waddr   = base_ptr[ADDR_W-1:0];
                    wr_ptr_next = base_ptr + 1'b1;
                    if (in_endofpacket) begin
                        wr_commit_next = base_ptr + 1'b1;
                        commit_evt     = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        state_next = PKT;
                    end
                end
            end else begin
                case (state_reg)
                    PKT: begin
                        if ((wr_ptr_reg - rd_ptr_reg) == DEPTH_P) begin
                            wr_ptr_next = wr_commit_reg;
                            drop_inc    = 2'd1;
                            state_next  = in_endofpacket ? IDLE : DROP;
                        end else begin
                            ram_we      = 1'b1;
                            wr_ptr_next = wr_ptr_reg + 1'b1;
                            if (in_endofpacket) begin
                                wr_commit_next = wr_ptr_reg + 1'b1;
                                commit_evt     = 1'b1;
                                state_next     = IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (in_endofpacket) begin
                            state_next = IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            wr_commit_reg <= '0;
            in_ready_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            wr_commit_reg <= wr_commit_next;
            in_ready_reg  <= 1'b1;
        end
    end

    // ---------------- storage ----------------
    logic             ram_re;
    logic [ENTRY_W-1:0] ram_rdata_raw;
    entry_t           ram_rdata;

    sonic_vc_sdp_ram #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (wr_entry),
        .re    (ram_re),
        .raddr (rd_ptr_reg[ADDR_W-1:0]),
        .rdata (ram_rdata_raw)
    );

    assign ram_rdata = entry_t'(ram_rdata_raw);

    // ---------------- read side / prefetch ----------------
    logic       rd_inflight_reg;
    logic       out_valid_reg;
    entry_t     out_entry_reg;
    logic       skid_valid_reg;
    entry_t     skid_entry_reg;
    logic       pop;
    logic       out_free;
    logic [1:0] held_after_pop;

    assign pop      = out_valid_reg && out_ready;
    assign out_free = !out_valid_reg || out_ready;

    // Reads are issued only while the two output registers can absorb the beat in flight.
    assign held_after_pop = 2'(out_valid_reg && !out_ready) + 2'(skid_valid_reg) + 2'(rd_inflight_reg);
    assign ram_re         = (rd_ptr_reg != wr_commit_reg) && (held_after_pop < 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg      <= '0;
            rd_inflight_reg <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_entry_reg   <= '0;
            skid_valid_reg  <= 1'b0;
            skid_entry_reg  <= '0;
        end else begin
            if (ram_re) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            rd_inflight_reg <= ram_re;
            if (out_free) begin
                if (skid_valid_reg) begin
                    out_entry_reg  <= skid_entry_reg;
                    out_valid_reg  <= 1'b1;
                    skid_valid_reg <= rd_inflight_reg;
                    if (rd_inflight_reg) begin
                        skid_entry_reg <= ram_rdata;
                    end
                end else if (rd_inflight_reg) begin
                    out_entry_reg <= ram_rdata;
                    out_valid_reg <= 1'b1;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end else if (rd_inflight_reg) begin
                skid_entry_reg <= ram_rdata;
                skid_valid_reg <= 1'b1;
            end
        end
    end

    assign out_valid         = out_valid_reg;
    assign out_data          = out_entry_reg.data;
    assign out_startofpacket = out_entry_reg.sop;
    assign out_endofpacket   = out_entry_reg.eop;
    assign out_empty         = out_entry_reg.empty;

    // ---------------- counters ----------------
    logic [ADDR_W:0] pkt_count_reg;
    logic [31:0]     drop_count_reg;
    logic [32:0]     drop_sum;
    logic            pop_eop;

    assign pop_eop  = pop && out_entry_reg.eop;
    assign drop_sum = {1'b0, drop_count_reg} + 33'(drop_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            case ({commit_evt, pop_eop})
                2'b10:   pkt_count_reg <= pkt_count_reg + 1'b1;
                2'b01:   pkt_count_reg <= pkt_count_reg - 1'b1;
                default: pkt_count_reg <= pkt_count_reg;
            endcase
            drop_count_reg <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end

    assign pkt_count  = pkt_count_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_sonic_vc_rx_pkt_fifo.sv
// Directed bench for the receive packet FIFO at DEPTH=16; one line printed per output beat.
module tb_sonic_vc_rx_pkt_fifo;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_ready;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_startofpacket;
    logic         in_endofpacket;
    logic [1:0]   in_empty;
    logic         out_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_startofpacket;
    logic         out_endofpacket;
    logic [1:0]   out_empty;
    logic [4:0]   pkt_count;
    logic [31:0]  drop_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int           cyc;
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [1:0]   emp;
    } beat_t;

    beat_t mq[$];

    sonic_vc_rx_pkt_fifo #(
        .DATA_W  (128),
        .EMPTY_W (2),
        .DEPTH   (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .pkt_count         (pkt_count),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transferred output beat; out_ready only changes just after a rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            mq.push_back('{cyc: cyc, data: out_data, sop: out_startofpacket,
                           eop: out_endofpacket, emp: out_empty});
            $display("out beat cyc=%0d data=%0h sop=%0b eop=%0b empty=%0d",
                     cyc, out_data, out_startofpacket, out_endofpacket, out_empty);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic sop, input logic eop, input logic [1:0] emp, input logic [127:0] d);
        in_valid         = 1'b1;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = emp;
        in_data          = d;
        @(posedge clk);
        #1;
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [127:0] d,
                            input logic sop, input logic eop, input logic [1:0] emp);
        if (idx < mq.size()) begin
            chk({tag, "_data"}, mq[idx].data, d);
            chk({tag, "_sop"}, 128'(mq[idx].sop), 128'(sop));
            chk({tag, "_eop"}, 128'(mq[idx].eop), 128'(eop));
            chk({tag, "_empty"}, 128'(mq[idx].emp), 128'(emp));
        end
    endtask

    initial begin
        logic [127:0] a5;
        a5 = {16{8'hA5}};
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_startofpacket = 1'b0;
        in_endofpacket = 1'b0;
        in_empty = '0;
        out_ready = 1'b1;
        step(3);

        // Reset state
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("rst_drop_count", 128'(drop_count), 128'(0));
        reset = 1'b0;
        step(1);
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        // Single 1-beat packet: out_valid two edges after the accepting edge
        mq.delete();
        send(1'b1, 1'b1, 2'd2, a5);
        chk("s1_pkt_count_commit", 128'(pkt_count), 128'(1));
        chk("s1_valid_e1", 128'(out_valid), 128'(0));
        step(1);
        chk("s1_valid_e2", 128'(out_valid), 128'(0));
        step(1);
        chk("s1_valid_e3", 128'(out_valid), 128'(1));
        chk("s1_data", out_data, a5);
        chk("s1_sop", 128'(out_startofpacket), 128'(1));
        chk("s1_eop", 128'(out_endofpacket), 128'(1));
        chk("s1_empty", 128'(out_empty), 128'(2));
        chk("s1_pkt_count_held", 128'(pkt_count), 128'(1));
        step(1);
        chk("s1_valid_after", 128'(out_valid), 128'(0));
        chk("s1_pkt_count_done", 128'(pkt_count), 128'(0));
        chk("s1_beats", 128'(mq.size()), 128'(1));

        // Three 4-beat packets back to back
        mq.delete();
        for (int i = 0; i < 12; i++) begin
            send((i % 4) == 0, (i % 4) == 3, 2'(i % 4), 128'(i + 16));
        end
        step(10);
        chk("s2_beats", 128'(mq.size()), 128'(12));
        for (int i = 0; i < 12 && i < mq.size(); i++) begin
            chk_beat("s2_beat", i, 128'(i + 16), (i % 4) == 0, (i % 4) == 3, 2'(i % 4));
            chk("s2_consecutive", 128'(mq[i].cyc - mq[0].cyc), 128'(i));
        end
        chk("s2_drop_count", 128'(drop_count), 128'(0));
        chk("s2_pkt_count", 128'(pkt_count), 128'(0));

        // Stalled output: 20-beat packet overflows behind a committed 4-beat packet
        mq.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(i == 0, i == 3, 2'd0, 128'(32'h100 + i));
        end
        for (int i = 0; i < 20; i++) begin
            send(i == 0, i == 19, 2'd1, 128'(32'h300 + i));
        end
        step(3);
        chk("s3_drop_count", 128'(drop_count), 128'(1));
        chk("s3_pkt_count", 128'(pkt_count), 128'(1));
        chk("s3_hold_valid", 128'(out_valid), 128'(1));
        chk("s3_hold_data", out_data, 128'(32'h100));
        step(2);
        chk("s3_hold_data_later", out_data, 128'(32'h100));
        chk("s3_hold_sop", 128'(out_startofpacket), 128'(1));
        out_ready = 1'b1;
        step(10);
        chk("s3_beats", 128'(mq.size()), 128'(4));
        for (int i = 0; i < 4 && i < mq.size(); i++) begin
            chk_beat("s3_beat", i, 128'(32'h100 + i), i == 0, i == 3, 2'd0);
        end
        chk("s3_pkt_count_done", 128'(pkt_count), 128'(0));

        // Truncated packet (new SOP without EOP) is rolled back
        mq.delete();
        send(1'b1, 1'b0, 2'd0, 128'(32'h500));
        send(1'b0, 1'b0, 2'd0, 128'(32'h501));
        send(1'b1, 1'b0, 2'd0, 128'(32'h200));
        send(1'b0, 1'b0, 2'd0, 128'(32'h201));
        send(1'b0, 1'b1, 2'd3, 128'(32'h202));
        step(8);
        chk("s4_drop_count", 128'(drop_count), 128'(2));
        chk("s4_beats", 128'(mq.size()), 128'(3));
        for (int i = 0; i < 3 && i < mq.size(); i++) begin
            chk_beat("s4_beat", i, 128'(32'h200 + i), i == 0, i == 2, (i == 2) ? 2'd3 : 2'd0);
        end

        // Orphan beats while idle
        mq.delete();
        send(1'b0, 1'b0, 2'd0, 128'(32'h600));
        send(1'b0, 1'b1, 2'd0, 128'(32'h601));
        send(1'b0, 1'b0, 2'd0, 128'(32'h602));
        step(6);
        chk("s5_beats", 128'(mq.size()), 128'(0));
        chk("s5_drop_count", 128'(drop_count), 128'(2));
        chk("s5_pkt_count", 128'(pkt_count), 128'(0));

        // Reset mid-packet with two committed packets stored
        mq.delete();
        out_ready = 1'b0;
        send(1'b1, 1'b0, 2'd0, 128'(32'h700));
        send(1'b0, 1'b1, 2'd0, 128'(32'h701));
        send(1'b1, 1'b0, 2'd0, 128'(32'h710));
        send(1'b0, 1'b1, 2'd0, 128'(32'h711));
        send(1'b1, 1'b0, 2'd0, 128'(32'h720));
        send(1'b0, 1'b0, 2'd0, 128'(32'h721));
        chk("s6_pkt_count_pre", 128'(pkt_count), 128'(2));
        chk("s6_valid_pre", 128'(out_valid), 128'(1));
        reset = 1'b1;
        step(1);
        chk("s6_rst_valid", 128'(out_valid), 128'(0));
        chk("s6_rst_data", out_data, 128'(0));
        chk("s6_rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("s6_rst_drop_count", 128'(drop_count), 128'(0));
        chk("s6_rst_in_ready", 128'(in_ready), 128'(0));
        step(1);
        reset = 1'b0;
        out_ready = 1'b1;
        step(1);
        send(1'b1, 1'b0, 2'd0, 128'(32'h400));
        send(1'b0, 1'b1, 2'd1, 128'(32'h401));
        step(8);
        chk("s6_beats", 128'(mq.size()), 128'(2));
        chk_beat("s6_beat0", 0, 128'(32'h400), 1'b1, 1'b0, 2'd0);
        chk_beat("s6_beat1", 1, 128'(32'h401), 1'b0, 1'b1, 2'd1);
        chk("s6_pkt_count_done", 128'(pkt_count), 128'(0));
        chk("s6_drop_count_done", 128'(drop_count), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
